// File: rtl/bch_syndrome_stream_if.sv
// Stream interface for the BCH syndrome front-end.
// master: codeword source (drives start/config and the bit beats, observes results).
// slave : syndrome engine (accepts beats, returns in_ready, busy, done, flags, syndromes).
interface bch_syndrome_stream_if #(
  parameter int P     = 8,
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
);
  logic                     start;
  logic [9:0]               n;
  logic [3:0]               t;
  logic [3:0]               m;
  logic                     in_valid;
  logic                     in_ready;
  logic [P-1:0]             in_bits;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;
  logic                     syn_zero;
  logic [2*T_MAX*M_MAX-1:0] syndromes;

  modport master (
    output start, n, t, m, in_valid, in_bits,
    input  in_ready, busy, done, cfg_err, syn_zero, syndromes
  );

  modport slave (
    input  start, n, t, m, in_valid, in_bits,
    output in_ready, busy, done, cfg_err, syn_zero, syndromes
  );
endinterface

// File: rtl/bch_syndrome_stream.sv
// Streaming BCH syndrome engine: S_1..S_2t over GF(2^m), m in {6,8,10} chosen per codeword.
// Ports: clk, rst (async active-high), bus (slave side of bch_syndrome_stream_if:
//   start/n/t/m config, in_valid/in_ready/in_bits beats, busy/done/cfg_err/syn_zero/syndromes).
module bch_syndrome_stream #(
  parameter int N_MAX = 1023,
  parameter int T_MAX = 4,
  parameter int M_MAX = 10,
  parameter int P     = 8
) (
  input logic                  clk,
  input logic                  rst,
  bch_syndrome_stream_if.slave bus
);

  localparam int         NS  = 2 * T_MAX;
  localparam logic [9:0] P_N = 10'(P);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start_q;
  logic [3:0]       t_r;
  logic [3:0]       m_r;
  logic [9:0]       remaining;
  logic             cfg_err_r;
  logic             res_vld;
  logic [M_MAX-1:0] syn     [1:NS];
  logic [M_MAX-1:0] syn_nxt [1:NS];

  logic       start_go;
  logic       cfg_bad;
  logic       beat;
  logic       last_beat;
  logic [9:0] k;
  int         nlim;

  // Multiply a field element by alpha: shift up one and fold the overflow bit
  // back through the primitive polynomial of the selected field.
  function automatic logic [M_MAX-1:0] mul_alpha(input logic [M_MAX-1:0] x,
                                                 input logic [3:0]       mm);
    logic [M_MAX-1:0] sh;
    logic [M_MAX-1:0] r;
    sh = {x[M_MAX-2:0], 1'b0};
    r  = '0;
    case (mm)
      4'd6:    r = (sh & M_MAX'(10'h03f)) ^ (x[5] ? M_MAX'(10'h003) : '0);
      4'd8:    r = (sh & M_MAX'(10'h0ff)) ^ (x[7] ? M_MAX'(10'h01d) : '0);
      4'd10:   r = (sh & M_MAX'(10'h3ff)) ^ (x[9] ? M_MAX'(10'h009) : '0);
      default: r = '0;
    endcase
    return r;
  endfunction

  // x * alpha^j as j repeated single-step multiplications (j <= 2*T_MAX).
  function automatic logic [M_MAX-1:0] mul_alpha_pow(input logic [M_MAX-1:0] x,
                                                     input int               j,
                                                     input logic [3:0]       mm);
    logic [M_MAX-1:0] r;
    r = x;
    for (int i = 0; i < NS; i++) begin
      if (i < j) r = mul_alpha(r, mm);
    end
    return r;
  endfunction

  // Configuration legality, evaluated on the live inputs at start.
  always_comb begin
    cfg_bad = 1'b0;
    nlim    = 0;
    case (bus.m)
      4'd6:    nlim = 63;
      4'd8:    nlim = 255;
      4'd10:   nlim = 1023;
      default: cfg_bad = 1'b1;
    endcase
    if (bus.t == 4'd0 || int'(bus.t) > T_MAX || bus.n == 10'd0 ||
        int'(bus.n) > nlim || int'(bus.n) > N_MAX)
      cfg_bad = 1'b1;
  end

  // Only a rising edge of start is honoured, so a held start launches one
  // codeword. start_q resets high so a start present at reset release is ignored.
  assign start_go  = (state == IDLE) && bus.start && !start_q;
  assign k         = (remaining < P_N) ? remaining : P_N;
  assign beat      = (state == LOAD) && bus.in_valid;
  assign last_beat = beat && (remaining == k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_nxt = cfg_bad ? FIN : LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (last_beat) state_nxt = FIN;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Horner step per used lane: S_j = S_j*alpha^j + bit. Lane 0 carries the
  // highest remaining index, so lanes are folded in ascending order. Syndromes
  // above 2t are never touched and stay at their cleared value of zero.
  always_comb begin
    logic [M_MAX-1:0] acc;
    acc = '0;
    for (int j = 1; j <= NS; j++) begin
      acc = syn[j];
      if (j <= 2 * int'(t_r)) begin
        for (int l = 0; l < P; l++) begin
          if (l < int'(k))
            acc = mul_alpha_pow(acc, j, m_r) ^ {{(M_MAX-1){1'b0}}, bus.in_bits[l]};
        end
      end
      syn_nxt[j] = acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b1;
      t_r       <= '0;
      m_r       <= '0;
      remaining <= '0;
      cfg_err_r <= 1'b0;
      res_vld   <= 1'b0;
      for (int j = 1; j <= NS; j++) syn[j] <= '0;
    end else begin
      start_q <= bus.start;
      if (start_go) begin
        t_r       <= bus.t;
        m_r       <= bus.m;
        remaining <= bus.n;
        cfg_err_r <= cfg_bad;
        // An illegal config goes straight to FIN, so its result is valid now.
        res_vld   <= cfg_bad;
        for (int j = 1; j <= NS; j++) syn[j] <= '0;
      end else if (beat) begin
        remaining <= remaining - k;
        for (int j = 1; j <= NS; j++) syn[j] <= syn_nxt[j];
        if (last_beat) res_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.syndromes = '0;
    for (int j = 1; j <= NS; j++) bus.syndromes[(j-1)*M_MAX +: M_MAX] = syn[j];
  end

  // Result flags hold from FIN until the next start clears res_vld.
  assign bus.cfg_err  = cfg_err_r;
  assign bus.syn_zero = res_vld && !cfg_err_r && (bus.syndromes == '0);

endmodule
